// File: rtl/simon_key_scheduler_if.sv
// Handshake bundle between the SIMON key scheduler, its key source and the round-function stage.
// The scheduler uses the slave view; the key source / round consumer uses the master view.
interface simon_key_scheduler_if #(
  parameter int N  = 16,
  parameter int M  = 4,
  parameter int CB = 5
);
  logic           key_valid;
  logic [M*N-1:0] key_in;
  logic           key_ready;
  logic           rk_valid;
  logic           rk_ready;
  logic [N-1:0]   rk_out;
  logic [CB-1:0]  rk_round;
  logic           busy;
  logic           done;

  modport slave (
    input  key_valid, key_in, rk_ready,
    output key_ready, rk_valid, rk_out, rk_round, busy, done
  );

  modport master (
    output key_valid, key_in, rk_ready,
    input  key_ready, rk_valid, rk_out, rk_round, busy, done
  );
endinterface

// File: rtl/simon_key_scheduler.sv
// SIMON key schedule: holds a sliding window of the M newest key words and issues one round
// key per handshake, expanding the next word on the fly instead of storing the whole schedule.
module simon_key_scheduler #(
  parameter int N  = 16,
  parameter int M  = 4,
  parameter int T  = 32,
  parameter int J  = 0,
  parameter int CB = $clog2(T)
) (
  input  logic                        clk,
  input  logic                        rst,
  simon_key_scheduler_if.slave        bus
);

  typedef enum logic {IDLE, RUN} state_t;

  // Element 0 of each z sequence sits at index 0 of the ascending range.
  localparam logic [0:61] Z0 = 62'b11111010001001010110000111001101111101000100101011000011100110;
  localparam logic [0:61] Z1 = 62'b10001110111110010011000010110101000111011111001001100001011010;
  localparam logic [0:61] Z2 = 62'b10101111011100000011010010011000101000010001111110010110110011;
  localparam logic [0:61] Z3 = 62'b11011011101011000110010111100000010010001010011100110100001111;
  localparam logic [0:61] Z4 = 62'b11010001111001101011011000100000010111000011001010010011101111;
  localparam logic [0:61] ZSEL = (J == 0) ? Z0 :
                                 (J == 1) ? Z1 :
                                 (J == 2) ? Z2 :
                                 (J == 3) ? Z3 : Z4;

  localparam logic [CB-1:0] LAST_ROUND = CB'(T - 1);
  localparam logic [N-1:0]  CONST_3    = N'(3);
  localparam logic [5:0]    ZIDX_LAST  = 6'd61;

  state_t        state_q, state_d;
  logic [N-1:0]  win_q [M];
  logic [N-1:0]  win_d [M];
  logic [CB-1:0] count_q, count_d;
  logic [5:0]    zidx_q, zidx_d;
  logic          done_q, done_d;

  logic [N-1:0]  tmp;
  logic [N-1:0]  next_word;
  logic          key_hs;
  logic          rk_hs;
  logic          last_rk;

  // zidx tracks count mod 62 incrementally so no divider is needed for the z wrap.
  always_comb begin
    tmp = {win_q[M-1][2:0], win_q[M-1][N-1:3]};
    if (M == 4) begin
      tmp = tmp ^ win_q[1];
    end
    next_word = ~win_q[0] ^ tmp ^ {tmp[0], tmp[N-1:1]}
                ^ {{(N-1){1'b0}}, ZSEL[zidx_q]} ^ CONST_3;
  end

  assign key_hs  = (state_q == IDLE) && bus.key_valid;
  assign rk_hs   = (state_q == RUN) && bus.rk_ready;
  assign last_rk = (count_q == LAST_ROUND);

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    zidx_d  = zidx_q;
    done_d  = 1'b0;
    win_d   = win_q;
    case (state_q)
      IDLE: begin
        if (key_hs) begin
          state_d = RUN;
          count_d = '0;
          zidx_d  = '0;
          for (int i = 0; i < M; i++) begin
            win_d[i] = bus.key_in[i*N +: N];
          end
        end
      end
      RUN: begin
        if (rk_hs) begin
          if (last_rk) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            for (int i = 0; i < M - 1; i++) begin
              win_d[i] = win_q[i+1];
            end
            win_d[M-1] = next_word;
            count_d    = count_q + CB'(1);
            zidx_d     = (zidx_q == ZIDX_LAST) ? 6'd0 : zidx_q + 6'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      zidx_q  <= '0;
      done_q  <= 1'b0;
      for (int i = 0; i < M; i++) begin
        win_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      zidx_q  <= zidx_d;
      done_q  <= done_d;
      for (int i = 0; i < M; i++) begin
        win_q[i] <= win_d[i];
      end
    end
  end

  // Window head and count are registered, so rk_out/rk_round hold still through stalls and IDLE.
  assign bus.key_ready = (state_q == IDLE);
  assign bus.rk_valid  = (state_q == RUN);
  assign bus.busy      = (state_q == RUN);
  assign bus.rk_out    = win_q[0];
  assign bus.rk_round  = count_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_simon_key_scheduler.sv
// Scoreboard bench for simon_key_scheduler: a software key-expansion model fills the expected
// queue at each key load, and entries are popped as round keys are accepted.
module tb_simon_key_scheduler;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [63:0] key;
    int          round;
  } exp_t;
  exp_t sb_q[$];

  localparam logic [255:0] TV_KEY = 256'h1918_1110_0908_0100;
  logic [15:0] tv [8] = '{16'h0100, 16'h0908, 16'h1110, 16'h1918,
                          16'h71C3, 16'hB649, 16'h56D4, 16'hE070};

  simon_key_scheduler_if #(.N(16), .M(4), .CB(5)) if_a ();
  simon_key_scheduler_if #(.N(64), .M(2), .CB(7)) if_b ();
  simon_key_scheduler_if #(.N(32), .M(3), .CB(6)) if_c ();

  simon_key_scheduler #(.N(16), .M(4), .T(32), .J(0), .CB(5)) dut_a (.clk(clk), .rst(rst), .bus(if_a));
  simon_key_scheduler #(.N(64), .M(2), .T(68), .J(2), .CB(7)) dut_b (.clk(clk), .rst(rst), .bus(if_b));
  simon_key_scheduler #(.N(32), .M(3), .T(42), .J(2), .CB(6)) dut_c (.clk(clk), .rst(rst), .bus(if_c));

  function automatic void sched_params(input int sel, output int n, output int m, output int t, output int j);
    case (sel)
      0:       begin n = 16; m = 4; t = 32; j = 0; end
      1:       begin n = 64; m = 2; t = 68; j = 2; end
      default: begin n = 32; m = 3; t = 42; j = 2; end
    endcase
  endfunction

  function automatic logic zbit(input int j, input int idx);
    logic [0:61] z;
    case (j)
      0:       z = 62'b11111010001001010110000111001101111101000100101011000011100110;
      1:       z = 62'b10001110111110010011000010110101000111011111001001100001011010;
      2:       z = 62'b10101111011100000011010010011000101000010001111110010110110011;
      3:       z = 62'b11011011101011000110010111100000010010001010011100110100001111;
      default: z = 62'b11010001111001101011011000100000010111000011001010010011101111;
    endcase
    return z[idx];
  endfunction

  function automatic logic [63:0] ror(input logic [63:0] x, input int r, input int n, input logic [63:0] mask);
    return ((x >> r) | (x << (n - r))) & mask;
  endfunction

  function automatic void fill_sb(input int sel, input logic [255:0] key);
    int n, m, t, j;
    logic [63:0] mask, tmp;
    logic [63:0] k [128];
    sched_params(sel, n, m, t, j);
    mask = (n == 64) ? {64{1'b1}} : ((64'd1 << n) - 64'd1);
    for (int i = 0; i < m; i++) k[i] = 64'(key >> (i * n)) & mask;
    for (int i = 0; i < t - m; i++) begin
      tmp = ror(k[i+m-1], 3, n, mask);
      if (m == 4) tmp = tmp ^ k[i+1];
      k[i+m] = (~k[i] ^ tmp ^ ror(tmp, 1, n, mask) ^ 64'(zbit(j, i % 62)) ^ 64'd3) & mask;
    end
    for (int i = 0; i < t; i++) sb_q.push_back('{k[i], i});
  endfunction

  function automatic void get_out(input int sel, output logic v, output logic [63:0] d, output logic [7:0] r,
                                  output logic dn, output logic kr, output logic bz);
    case (sel)
      0:       begin v = if_a.rk_valid; d = 64'(if_a.rk_out); r = 8'(if_a.rk_round);
                     dn = if_a.done; kr = if_a.key_ready; bz = if_a.busy; end
      1:       begin v = if_b.rk_valid; d = 64'(if_b.rk_out); r = 8'(if_b.rk_round);
                     dn = if_b.done; kr = if_b.key_ready; bz = if_b.busy; end
      default: begin v = if_c.rk_valid; d = 64'(if_c.rk_out); r = 8'(if_c.rk_round);
                     dn = if_c.done; kr = if_c.key_ready; bz = if_c.busy; end
    endcase
  endfunction

  task automatic set_key(input int sel, input logic v, input logic [255:0] key);
    case (sel)
      0:       begin if_a.key_valid = v; if_a.key_in = key[63:0];  end
      1:       begin if_b.key_valid = v; if_b.key_in = key[127:0]; end
      default: begin if_c.key_valid = v; if_c.key_in = key[95:0];  end
    endcase
  endtask

  task automatic set_ready(input int sel, input logic v);
    case (sel)
      0:       if_a.rk_ready = v;
      1:       if_b.rk_ready = v;
      default: if_c.rk_ready = v;
    endcase
  endtask

  // Called just after a negedge; returns one negedge after the accepting posedge.
  task automatic load_key(input int sel, input logic [255:0] key, input bit hold, input logic [255:0] key2);
    int guard = 0;
    logic v, dn, kr, bz;
    logic [63:0] d;
    logic [7:0] r;
    set_key(sel, 1'b1, key);
    get_out(sel, v, d, r, dn, kr, bz);
    while (kr !== 1'b1 && guard < 20) begin
      @(negedge clk);
      get_out(sel, v, d, r, dn, kr, bz);
      guard++;
    end
    total++;
    if (kr !== 1'b1) begin
      bad++;
      $display("[TB] FAIL key_accept sel=%0d key_ready=%b want=1", sel, kr);
      set_key(sel, 1'b0, key);
      return;
    end
    fill_sb(sel, key);
    @(posedge clk);
    @(negedge clk);
    set_key(sel, hold, hold ? key2 : key);
    get_out(sel, v, d, r, dn, kr, bz);
    total++;
    if (v !== 1'b1 || r !== 8'd0) begin
      bad++;
      $display("[TB] FAIL first_latency sel=%0d valid=%b round=%0d want valid=1 round=0", sel, v, r);
    end
  endtask

  task automatic drain(input int sel, input bit stall, input bit check_tv, input bit linger);
    int cyc = 0, early_done = 0, n, m, t, j;
    bit stalled = 1'b0;
    logic rdy;
    logic v, dn, kr, bz;
    logic [63:0] d, prev_d = '0, last_d = '0;
    logic [7:0] r, prev_r = '0;
    exp_t e;
    sched_params(sel, n, m, t, j);
    while (sb_q.size() != 0 && cyc < 1000) begin
      get_out(sel, v, d, r, dn, kr, bz);
      if (dn === 1'b1) early_done++;
      total++;
      if (v !== 1'b1) begin
        bad++;
        $display("[TB] FAIL no_bubble sel=%0d cyc=%0d valid=%b want=1", sel, cyc, v);
      end
      if (stalled) begin
        total++;
        if (d !== prev_d || r !== prev_r) begin
          bad++;
          $display("[TB] FAIL stall_hold sel=%0d got %h/%0d want %h/%0d", sel, d, r, prev_d, prev_r);
        end
      end
      rdy = stall ? ((cyc % 3) == 0) : 1'b1;
      set_ready(sel, rdy);
      if (v === 1'b1 && rdy) begin
        e = sb_q.pop_front();
        total++;
        if (d !== e.key || r !== 8'(e.round)) begin
          bad++;
          $display("[TB] FAIL rk_data sel=%0d got %h/%0d want %h/%0d", sel, d, r, e.key, e.round);
        end
        if (check_tv && e.round < 8) begin
          total++;
          if (d[15:0] !== tv[e.round]) begin
            bad++;
            $display("[TB] FAIL tv_vector round=%0d got %h want %h", e.round, d[15:0], tv[e.round]);
          end
        end
        last_d  = e.key;
        stalled = 1'b0;
      end else begin
        stalled = (v === 1'b1);
        prev_d  = d;
        prev_r  = r;
      end
      @(negedge clk);
      cyc++;
    end
    if (sb_q.size() != 0) begin
      total++;
      bad++;
      $display("[TB] FAIL timeout sel=%0d remaining=%0d want 0", sel, sb_q.size());
      sb_q.delete();
      set_ready(sel, 1'b0);
      return;
    end
    get_out(sel, v, d, r, dn, kr, bz);
    total++;
    if (dn !== 1'b1 || early_done != 0) begin
      bad++;
      $display("[TB] FAIL done_pulse sel=%0d done=%b early=%0d want done=1 early=0", sel, dn, early_done);
    end
    total++;
    if (v !== 1'b0 || kr !== 1'b1 || bz !== 1'b0) begin
      bad++;
      $display("[TB] FAIL idle_return sel=%0d v/kr/busy=%b%b%b want 010", sel, v, kr, bz);
    end
    total++;
    if (r !== 8'(t - 1) || d !== last_d) begin
      bad++;
      $display("[TB] FAIL idle_retain sel=%0d got %h/%0d want %h/%0d", sel, d, r, last_d, t - 1);
    end
    if (linger) begin
      set_ready(sel, 1'b1);
      @(negedge clk);
      get_out(sel, v, d, r, dn, kr, bz);
      total++;
      if (dn !== 1'b0 || v !== 1'b0 || r !== 8'(t - 1) || d !== last_d) begin
        bad++;
        $display("[TB] FAIL idle_hold sel=%0d done=%b v=%b got %h/%0d want 0 0 %h/%0d",
                 sel, dn, v, d, r, last_d, t - 1);
      end
      set_ready(sel, 1'b0);
    end
  endtask

  task automatic test_reset();
    logic v, dn, kr, bz;
    logic [63:0] d;
    logic [7:0] r;
    rst = 1'b1;
    set_key(0, 1'b0, '0); set_key(1, 1'b0, '0); set_key(2, 1'b0, '0);
    set_ready(0, 1'b0); set_ready(1, 1'b0); set_ready(2, 1'b0);
    repeat (2) @(negedge clk);
    get_out(0, v, d, r, dn, kr, bz);
    total++;
    if (v !== 1'b0 || d !== 64'd0 || r !== 8'd0 || kr !== 1'b1 || bz !== 1'b0 || dn !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_state v=%b d=%h r=%0d kr=%b busy=%b done=%b want 0 0 0 1 0 0", v, d, r, kr, bz, dn);
    end
    rst = 1'b0;
    @(negedge clk);
    get_out(1, v, d, r, dn, kr, bz);
    total++;
    if (v !== 1'b0 || kr !== 1'b1 || dn !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_release v=%b kr=%b done=%b want 0 1 0", v, kr, dn);
    end
  endtask

  task automatic test_nominal();
    load_key(0, TV_KEY, 1'b0, '0);
    drain(0, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic test_stall();
    load_key(0, TV_KEY, 1'b0, '0);
    drain(0, 1'b1, 1'b1, 1'b1);
  endtask

  task automatic test_hold_key();
    logic [255:0] k2 = '0;
    k2[63:0] = {$urandom(), $urandom()};
    load_key(0, TV_KEY, 1'b1, k2);
    drain(0, 1'b0, 1'b1, 1'b0);
    load_key(0, k2, 1'b0, '0);
    drain(0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_async_reset();
    int guard = 0, done_seen = 0;
    logic v, dn, kr, bz;
    logic [63:0] d;
    logic [7:0] r;
    load_key(0, TV_KEY, 1'b0, '0);
    set_ready(0, 1'b1);
    get_out(0, v, d, r, dn, kr, bz);
    while (r !== 8'd10 && guard < 40) begin
      @(negedge clk);
      get_out(0, v, d, r, dn, kr, bz);
      guard++;
    end
    total++;
    if (r !== 8'd10) begin
      bad++;
      $display("[TB] FAIL reach_round10 got=%0d want=10", r);
    end
    #2 rst = 1'b1;
    #1 get_out(0, v, d, r, dn, kr, bz);
    total++;
    if (v !== 1'b0 || d !== 64'd0 || r !== 8'd0 || kr !== 1'b1 || bz !== 1'b0 || dn !== 1'b0) begin
      bad++;
      $display("[TB] FAIL async_reset v=%b d=%h r=%0d kr=%b busy=%b done=%b want 0 0 0 1 0 0", v, d, r, kr, bz, dn);
    end
    sb_q.delete();
    set_ready(0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      get_out(0, v, d, r, dn, kr, bz);
      if (dn === 1'b1) done_seen++;
    end
    total++;
    if (done_seen != 0 || v !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_no_done done_seen=%0d v=%b want 0 0", done_seen, v);
    end
    load_key(0, TV_KEY, 1'b0, '0);
    drain(0, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic test_params();
    logic [255:0] kb = '0, kc = '0;
    kb[127:0] = {$urandom(), $urandom(), $urandom(), $urandom()};
    kc[95:0]  = {$urandom(), $urandom(), $urandom()};
    load_key(1, kb, 1'b0, '0);
    drain(1, 1'b0, 1'b0, 1'b1);
    load_key(2, kc, 1'b0, '0);
    drain(2, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic test_back_to_back();
    logic [255:0] kx = '0;
    kx[63:0] = {$urandom(), $urandom()};
    load_key(0, kx, 1'b0, '0);
    drain(0, 1'b0, 1'b0, 1'b0);
    load_key(0, TV_KEY, 1'b0, '0);
    drain(0, 1'b0, 1'b1, 1'b1);
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_stall();
    test_hold_key();
    test_async_reset();
    test_params();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
